// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write-port arbiter with locked bursts and clear-all sweep
//
// Purpose: shares the single write port of the register file among NREQ requesters.
// Arbitration is round-robin. A requester that presents last=0 locks the port until
// its last=1 beat is accepted. A separate sweep clears every register, one per cycle.
//
// Ports:
//   clk, clr_n     clock (rising edge), asynchronous active-low reset
//   req            per-requester write request (level)
//   waddr, wdata   per-requester address / data, packed at [i*AW +: AW] / [i*DW +: DW]
//   last           per-requester final-beat flag (0 keeps the port locked)
//   clear_all_req  request a clear sweep of the whole register file (level)
//   gnt            combinational one-hot beat accept
//   reg_en         registered one-hot register load enable
//   reg_clr        registered one-hot register clear
//   bus_d          registered write data
//   busy           registered, high while not idle
//   clear_done     registered one-cycle pulse at the end of a sweep
module reg_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int ZERO_RO = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] waddr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    last,
  input  logic             clear_all_req,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_en,
  output logic [NREG-1:0]    reg_clr,
  output logic [DW-1:0]      bus_d,
  output logic             busy,
  output logic             clear_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   sel;
  logic            any_req;
  logic [AW-1:0]   sweep, sweep_nxt;
  logic [NREQ-1:0] gnt_int;
  logic            beat;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin pick: walk offsets from the highest down so the requester closest
  // to (at or after) the pointer is the last one written and therefore wins.
  always_comb begin
    int j;
    win     = '0;
    any_req = 1'b0;
    j       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win     = PW'(j);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    sweep_nxt = sweep;
    gnt_int   = '0;
    sel       = win;
    case (state)
      IDLE: begin
        if (clear_all_req) begin
          state_nxt = CLEAR;
          sweep_nxt = '0;
        end else if (any_req) begin
          gnt_int[win] = 1'b1;
          if (last[win]) begin
            ptr_nxt = next_idx(win);
          end else begin
            state_nxt = BURST;
            owner_nxt = win;
          end
        end
      end
      BURST: begin
        // Port is locked to the owner; a dropped req simply stalls the burst.
        sel = owner;
        if (req[owner]) begin
          gnt_int[owner] = 1'b1;
          if (last[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = next_idx(owner);
          end
        end
      end
      CLEAR: begin
        if (sweep == AW'(NREG - 1)) begin
          state_nxt = IDLE;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt      = clr_n ? gnt_int : '0;
  assign beat     = |gnt_int;
  assign sel_addr = waddr[sel*AW +: AW];
  assign sel_data = wdata[sel*DW +: DW];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      sweep      <= '0;
      reg_en     <= '0;
      reg_clr    <= '0;
      bus_d      <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      sweep <= sweep_nxt;
      busy  <= (state_nxt != IDLE);

      // Register 0 is hard-wired when ZERO_RO is set: the beat is still accepted
      // so the requester makes progress, but no load enable is raised.
      if (beat && !((ZERO_RO != 0) && (sel_addr == '0))) begin
        reg_en <= NREG'(1) << sel_addr;
      end else begin
        reg_en <= '0;
      end
      if (beat) begin
        bus_d <= sel_data;
      end

      // reg_clr is presented one cycle ahead in register form, so it shows
      // index k during the cycle the sweep counter holds k.
      if (state_nxt == CLEAR) begin
        reg_clr <= NREG'(1) << sweep_nxt;
      end else begin
        reg_clr <= '0;
      end
      clear_done <= (state == CLEAR) && (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed-vector bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [3:0]   req;
  logic [15:0]  waddr;
  logic [127:0] wdata;
  logic [3:0]   last;
  logic         clear_all_req;
  logic [3:0]   gnt;
  logic [15:0]  reg_en;
  logic [15:0]  reg_clr;
  logic [31:0]  bus_d;
  logic         busy;
  logic         clear_done;

  int n_chk = 0;
  int n_err = 0;

  reg_write_arbiter #(
    .NREQ(4), .NREG(16), .AW(4), .DW(32), .ZERO_RO(1)
  ) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .waddr(waddr), .wdata(wdata), .last(last),
    .clear_all_req(clear_all_req), .gnt(gnt), .reg_en(reg_en), .reg_clr(reg_clr),
    .bus_d(bus_d), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [3:0] a, input logic [31:0] d, input logic l);
    waddr[i*4 +: 4]  = a;
    wdata[i*32 +: 32] = d;
    last[i]          = l;
  endtask

  initial begin
    logic [3:0]  exp_g;
    logic [15:0] exp_oh;
    int          r;

    // 1: reset with everything asserted
    clr_n = 1'b0; req = 4'hF; clear_all_req = 1'b1; last = 4'hF; waddr = '0; wdata = '0;
    for (int i = 0; i < 4; i++) set_port(i, 4'(i + 1), 32'hA0 + i, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_reg_en", 32'(reg_en), 32'h0);
    check("rst_reg_clr", 32'(reg_clr), 32'h0);
    check("rst_bus_d", bus_d, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_clear_done", 32'(clear_done), 32'h0);
    @(negedge clk);
    clear_all_req = 1'b0; clr_n = 1'b1;
    #1;
    check("rel_gnt", 32'(gnt), 32'h1);

    // 3: all requesting, all single beats -> rotate
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      r = (k - 1) % 4;
      exp_g  = 4'b0001 << (k % 4);
      exp_oh = 16'h0001 << (r + 1);
      check("rr_gnt", 32'(gnt), 32'(exp_g));
      check("rr_reg_en", 32'(reg_en), 32'(exp_oh));
      check("rr_bus_d", bus_d, 32'hA0 + r);
    end
    @(negedge clk);
    req = 4'h0;
    #1;
    check("rr_last_en", 32'(reg_en), 32'h0002);
    @(negedge clk);
    #1;
    check("idle_en", 32'(reg_en), 32'h0);
    check("idle_bus_hold", bus_d, 32'hA0);

    // 2: single write, wrap from pointer 1 to requester 0
    @(negedge clk);
    req = 4'b0001; set_port(0, 4'd5, 32'hDEADBEEF, 1'b1);
    #1;
    check("single_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'h0;
    #1;
    check("single_en", 32'(reg_en), 32'h0020);
    check("single_bus", bus_d, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    check("single_en_once", 32'(reg_en), 32'h0);

    // 4: locked burst from requester 0 with a 2-cycle stall, req1 waiting
    @(negedge clk);
    req = 4'b0001; set_port(0, 4'd3, 32'h11, 1'b0);
    #1;
    check("burst_b1_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0010;
    #1;
    check("stall1_gnt", 32'(gnt), 32'h0);
    check("stall1_en", 32'(reg_en), 32'h0008);
    check("stall1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    check("stall2_gnt", 32'(gnt), 32'h0);
    check("stall2_en", 32'(reg_en), 32'h0);
    @(negedge clk);
    req = 4'b0011; set_port(0, 4'd6, 32'h22, 1'b0);
    #1;
    check("burst_b2_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    set_port(0, 4'd7, 32'h33, 1'b1);
    #1;
    check("burst_b3_gnt", 32'(gnt), 32'h1);
    check("burst_b2_en", 32'(reg_en), 32'h0040);
    @(negedge clk);
    req = 4'b0010; set_port(1, 4'd9, 32'h44, 1'b1);
    #1;
    check("after_burst_gnt", 32'(gnt), 32'h2);
    check("burst_b3_en", 32'(reg_en), 32'h0080);
    check("burst_b3_bus", bus_d, 32'h33);
    @(negedge clk);
    req = 4'h0;
    #1;
    check("req1_en", 32'(reg_en), 32'h0200);
    check("req1_busy", 32'(busy), 32'h0);

    // 5: clear sweep with requester 1 waiting
    @(negedge clk);
    req = 4'b0010; clear_all_req = 1'b1;
    #1;
    check("clr_start_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      clear_all_req = 1'b0;
      #1;
      exp_oh = 16'h0001 << k;
      check("sweep_clr", 32'(reg_clr), 32'(exp_oh));
      check("sweep_gnt", 32'(gnt), 32'h0);
      check("sweep_busy", 32'(busy), 32'h1);
      check("sweep_en", 32'(reg_en), 32'h0);
    end
    @(negedge clk);
    #1;
    check("clear_done", 32'(clear_done), 32'h1);
    check("sweep_end_clr", 32'(reg_clr), 32'h0);
    check("sweep_end_busy", 32'(busy), 32'h0);
    check("post_clr_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    req = 4'h0;
    #1;
    check("clear_done_pulse", 32'(clear_done), 32'h0);
    check("post_clr_en", 32'(reg_en), 32'h0200);

    // 6: write to read-only register 0, then reset mid-sweep
    @(negedge clk);
    req = 4'b0100; set_port(2, 4'd0, 32'h55, 1'b1);
    #1;
    check("ro_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    req = 4'h0;
    #1;
    check("ro_en", 32'(reg_en), 32'h0);
    @(negedge clk);
    clear_all_req = 1'b1;
    @(negedge clk);
    clear_all_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_pre_clr", 32'(reg_clr), 32'h0004);
    @(negedge clk);
    clr_n = 1'b0; req = 4'b0001; set_port(0, 4'd5, 32'h66, 1'b1);
    #1;
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_clr", 32'(reg_clr), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("abort_rel_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'h0;
    #1;
    check("abort_no_resume", 32'(reg_clr), 32'h0);
    check("abort_idle", 32'(busy), 32'h0);
    check("abort_write_en", 32'(reg_en), 32'h0020);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
